// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus between a binary producer and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (4'hF) in the result.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DW    = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [BIN_W-1:0]  shift_reg;
    logic [DW-1:0]     digits_reg;
    logic [DW-1:0]     digits_adj;
    logic [DW-1:0]     bcd_reg;
    logic [DW-1:0]     bcd_final;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ovf_scr_reg;
    logic              overflow_reg;
    logic              done_reg;
    logic              busy_next;
    logic              accept;
    logic              lz_seen;

    // A new request is taken whenever no shift sequence is running.
    assign accept = bus.start && (state_reg != SHIFT);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            always_comb begin
                digits_adj[4*gi +: 4] = digits_reg[4*gi +: 4];
                if (digits_reg[4*gi +: 4] >= 4'd5 && digits_reg[4*gi +: 4] <= 4'd9)
                    digits_adj[4*gi +: 4] = digits_reg[4*gi +: 4] + 4'd3;
            end
        end
    endgenerate

    always_comb begin
        bcd_final = digits_reg;
        lz_seen   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (digits_reg[4*i +: 4] != 4'd0)
                lz_seen = 1'b1;
            if (!lz_seen)
                bcd_final[4*i +: 4] = 4'hF;
        end
`endif
        if (ovf_scr_reg)
            bcd_final = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start)
                    state_next = SHIFT;
            end
            SHIFT: begin
                busy_next = 1'b1;
                if (cnt_reg == CNT_W'(1))
                    state_next = FINISH;
            end
            FINISH: begin
                state_next = bus.start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            digits_reg   <= '0;
            cnt_reg      <= '0;
            ovf_scr_reg  <= 1'b0;
            bcd_reg      <= '0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == FINISH) begin
                bcd_reg      <= bcd_final;
                overflow_reg <= ovf_scr_reg;
                done_reg     <= 1'b1;
            end
            if (accept) begin
                shift_reg   <= bus.bin;
                digits_reg  <= '0;
                ovf_scr_reg <= 1'b0;
                cnt_reg     <= CNT_W'(BIN_W);
            end else if (state_reg == SHIFT) begin
                // Any 1 leaving the top digit means the value cannot be shown.
                digits_reg  <= {digits_adj[DW-2:0], shift_reg[BIN_W-1]};
                shift_reg   <= {shift_reg[BIN_W-2:0], 1'b0};
                ovf_scr_reg <= ovf_scr_reg | digits_adj[DW-1];
                cnt_reg     <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign bus.busy     = busy_next;
    assign bus.done     = done_reg;
    assign bus.bcd      = bcd_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: randomized and directed conversions against a decimal model.
module tb_bin2bcd_seq;
    localparam int BW = 20;
    localparam int DG = 6;

    typedef struct {
        longint        val;
        logic [23:0]   bcd;
        logic          ovf;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    bin2bcd_seq_if #(.BIN_W(BW), .DIGITS(DG)) ifc ();

    bin2bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref_ovf(longint v);
        return v > 64'd999999;
    endfunction

    function automatic logic [23:0] ref_bcd(longint v);
        logic [23:0] r;
        longint p;
        r = '1;
        if (v > 64'd999999) return r;
        p = 1;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(string name, longint act, longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("[TB] bin=%0d bcd=%h ovf=%0b cycle=%0d", e.val, ifc.bcd, ifc.overflow, cyc);
                chk("bcd", ifc.bcd, e.bcd);
                chk("overflow", ifc.overflow, e.ovf);
                chk("done_latency", cyc, e.due);
            end
        end
    end

    function automatic void push(longint v);
        exp_t e;
        e.val = v;
        e.bcd = ref_bcd(v);
        e.ovf = ref_ovf(v);
        e.due = cyc + BW + 2;
        q.push_back(e);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (ifc.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (ifc.busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(longint v);
        wait_idle();
        ifc.bin = BW'(v);
        ifc.start = 1'b1;
        push(v);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("busy_after_start", ifc.busy, 1);
    endtask

    task automatic issue_at_done(longint v);
        int n = 0;
        while (!ifc.done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ifc.done) chk("done_timeout", 1, 0);
        ifc.bin = BW'(v);
        ifc.start = 1'b1;
        push(v);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("busy_after_done_start", ifc.busy, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        longint dir[10];
        dir = '{0, 999999, 123456, 1000000, 7, 42, 100000, 1048575, 9, 10};
        ifc.start = 1'b0;
        ifc.bin = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_bcd", ifc.bcd, 0);
        chk("rst_overflow", ifc.overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dir[i]) issue(dir[i]);
        drain();

        // A second start while busy must be ignored, and bin changes must not matter.
        issue(5);
        repeat (3) @(posedge clk);
        #1;
        ifc.bin = BW'(9);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        drain();

        // Start held in the done cycle is accepted at once.
        issue(123);
        issue_at_done(77);
        drain();

        // Reset mid-conversion aborts without a done pulse.
        wait_idle();
        ifc.bin = BW'(654321);
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", ifc.busy, 0);
        chk("abort_done", ifc.done, 0);
        chk("abort_bcd", ifc.bcd, 0);
        chk("abort_overflow", ifc.overflow, 0);
        repeat (BW + 5) @(posedge clk);
        #1;
        issue(31415);
        drain();

        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) issue(longint'($urandom_range(0, 999999)));
            else            issue(longint'($urandom_range(0, (1 << BW) - 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. Produces the packed BCD digit vector that drives the per-digit 7-segment decoders on the DE10-Lite HEX displays. It sits between the benchmark result/counter logic and the display decoders. A start/done handshake lets the producer launch a conversion and know when the digits are valid.

Parameters:
BIN_W, 20, width of binary input; legal range 4..32.
DIGITS, 6, number of BCD output digits; legal range 1..8.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  request conversion of bin; sampled only when idle.
bin  input  BIN_W  unsigned binary value; sampled in the cycle start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse; bcd and overflow are valid from this cycle on.
bcd  output  4*DIGITS  packed digits; digit 0 (units) in bits [3:0].
overflow  output  1  last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset: clk and rst_n only, synchronous and active-low. When rst_n=0 at a rising edge, the block clears to: state IDLE, busy=0, done=0, overflow=0, bcd=0, scratch registers 0.
- States:
  - IDLE: start=1 loads bin into the shift register, clears the digit scratch and overflow flag, loads bit counter = BIN_W, and moves to SHIFT. busy=1 from the next cycle.
  - SHIFT: each cycle, any scratch digit >=5 gets +3; the whole {digits, shift reg} is then shifted left by one. Counter decrements. When the counter reaches 1 (last shift performed), go to FINISH.
  - FINISH: copy scratch to bcd and latch overflow; done=1 for exactly this cycle; busy=0; next state IDLE.
- Latency: start sampled at edge N -> done high in the cycle after edge N+BIN_W+1. Back-to-back: start may be high in the done cycle and is accepted, because FINISH returns to IDLE behaviour for start.
- start while busy=1 is ignored; bin changes during SHIFT have no effect.
- bcd holds its last value between conversions; it changes only in FINISH or on reset.
- Overflow: a sticky scratch flag is set whenever a 1 is shifted out of the top digit during SHIFT. If the flag is set at FINISH, overflow=1 and every digit of bcd is 4'hF, so the downstream decoder blanks the display.
- Digit arithmetic is 4-bit; add-3 is applied only to values 5..9. Values never exceed 9 between shifts for in-range inputs.
- Reset during SHIFT aborts the conversion: no done pulse is issued and bcd returns to 0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: at FINISH, leading zero digits above the most significant non-zero digit are written as 4'hF (blank). Digit 0 is always kept, so value 0 shows as a single "0". Overflow still forces all digits to 4'hF.
- Undefined: all digits are output as computed, including leading zeros.

Test Plan:
- Reset then bin=0, start pulse -> done exactly BIN_W+1 cycles after the start edge (21 with defaults), bcd=24'h000000, overflow=0.
- bin=999999 -> bcd=24'h999999, overflow=0. bin=123456 -> bcd=24'h123456.
- bin=1000000 -> overflow=1, bcd=24'hFFFFFF. A following start with bin=7 -> overflow=0, bcd=24'h000007.
- Start bin=5, then re-pulse start with bin=9 at cycle 5 while busy -> second request ignored, result 24'h000005, only one done pulse. Start held high in the done cycle -> new conversion accepted immediately.
- rst_n=0 for one cycle mid-SHIFT -> no done, busy=0, bcd=0. A new conversion then completes normally.
- LEADING_ZERO_BLANK_EN defined: bin=42 -> 24'hFFFF42. bin=0 -> 24'hFFFFF0. bin=100000 -> 24'h100000.
